pipeline_stage_reg: RTL and testbench
=====================================

// Module: pipeline_stage_reg
// PURPOSE
//  Generic elastic pipeline latch replacing the fixed FD/DE/EM/MW latches: one payload of WIDTH
//  bits (a packed stage struct cast to logic), valid/ready handshake, synchronous flush, optional
//  2-entry skid buffer so in_ready is registered. Instantiated once per stage boundary in the
//  pipelined datapath; the hazard unit drives flush, the stage downstream drives out_ready.
// PARAMETERS
//  WIDTH      96   payload width in bits ($bits of the stage struct)
//  SKID       1    0: single register, in_ready combinational; 1: main + skid entry, in_ready registered
//  NOP_VALUE  '0   payload presented on out_data while out_valid=0 (bubble)
//  CNT_W      16   width of the saturating stall counter
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  RST        in   1      synchronous reset, active-high
//  flush      in   1      discard all held entries this edge
//  in_valid   in   1      upstream payload valid
//  in_ready   out  1      this stage accepts in_data this edge
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data holds a live payload
//  out_ready  in   1      downstream accepts out_data this edge
//  out_data   out  WIDTH  payload to downstream; NOP_VALUE when out_valid=0
//  occupancy  out  2      entries held: 0, 1 or 2 (2 only when SKID=1)
//  stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturates at all-ones
// BEHAVIOUR
//  - Transfer in: in_valid && in_ready at edge. Transfer out: out_valid && out_ready at edge.
//  - Latency: accepted payload appears on out_data the next cycle when stage was empty or draining.
//  - Reset (RST=1 at edge): out_valid=0, out_data=NOP_VALUE, occupancy=0, stall_cnt=0,
//    in_ready=1 from the following cycle; RST overrides flush and all transfers.
//  - SKID=1 FSM (stage_state_t): EMPTY, ONE (main full), TWO (main+skid full).
//      EMPTY: in xfer -> ONE (main<=in_data).
//      ONE:   in only -> TWO (skid<=in_data); out only -> EMPTY; in+out -> ONE (main<=in_data).
//      TWO:   out xfer -> ONE (main<=skid); in_ready=0 so no input.
//    in_ready = (state != TWO), driven from a flop; out_valid = (state != EMPTY); out_data = main.
//  - SKID=0: single entry; in_ready = !out_valid || out_ready (combinational); accept while
//    draining replaces payload the same edge; occupancy never exceeds 1.
//  - Ordering: strict FIFO; no payload dropped or duplicated except by flush/RST.
//  - flush=1 at edge: all entries invalidated, state->EMPTY, in_data offered that edge is dropped
//    even if in_ready=1, any out transfer that edge still counts as delivered to downstream.
//    stall_cnt not cleared by flush.
//  - stall_cnt increments when out_valid && !out_ready, holds at 2^CNT_W-1 (no wrap).
//  - in_data/out_ready with in_valid/out_valid low are ignored; X on in_data when in_valid=0
//    must not propagate to out_data.
// STRUCTURE
//  - pipeline_regs_pkg: add stage_state_t enum {EMPTY, ONE, TWO}, keep FD_t/DE_t/EM_t/MW_t;
//    callers instantiate WIDTH=$bits(DE_t) etc. and cast.
//  - Single module, generate-if on SKID; no sub-module required.
// TESTING
//  1 Reset: RST=1 2 cycles with in_valid=1 -> out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
//  2 Streaming: in_valid=1, out_ready=1, data 0x1,0x2,0x3 -> out_data 0x1,0x2,0x3 one cycle later,
//    occupancy stays 1, in_ready stays 1.
//  3 Backpressure SKID=1: out_ready=0, push 0xA,0xB -> occupancy 2, in_ready=0 next cycle; 0xC
//    held upstream; out_ready=1 -> outputs 0xA,0xB,0xC in order, stall_cnt counts stalled cycles.
//  4 Flush with full skid and in_valid=1 (0xD): next cycle out_valid=0, out_data=NOP_VALUE,
//    occupancy=0, 0xD never appears; stall_cnt unchanged.
//  5 Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15.
//  6 SKID=0: out_ready=0 with stage full -> in_ready=0 same cycle; out_ready=1, in_valid=1
//    (0x5) -> 0x5 on out_data next cycle, occupancy 1.

Source files
------------

// File: rtl/pipeline_regs_pkg.sv
// Shared pipeline types: the elastic-stage FSM encoding plus the per-boundary payload structs
// that callers pack into pipeline_stage_reg via WIDTH=$bits(<struct>) and a cast.
package pipeline_regs_pkg;

    // Encoding doubles as the occupancy count, so the top can drive occupancy straight from state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } FD_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] opA;
        logic [31:0] opB;
    } DE_t;

    typedef struct packed {
        logic [31:0] aluOut;
        logic [31:0] storeData;
        logic [4:0]  rd;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
    } EM_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regWrite;
    } MW_t;

endpackage

// File: rtl/pipeline_stage_reg.sv
// Elastic pipeline latch with valid/ready handshake, synchronous flush, optional two-entry skid
// buffer (registered in_ready) and a saturating count of downstream stall cycles.
module pipeline_stage_reg
    import pipeline_regs_pkg::*;
#(
    parameter int               WIDTH     = 96,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [CNT_W-1:0] r_stallCnt;

    generate
        if (SKID != 0) begin : gen_skid
            stage_state_t     r_state;
            stage_state_t     w_nextState;
            logic             r_inReady;
            logic [WIDTH-1:0] r_main;
            logic [WIDTH-1:0] r_skid;
            logic             w_inXfer;
            logic             w_outXfer;

            assign w_inXfer  = in_valid && r_inReady;
            assign w_outXfer = (r_state != EMPTY) && out_ready;

            always_comb begin
                w_nextState = r_state;
                if (flush) begin
                    w_nextState = EMPTY;
                end else begin
                    case (r_state)
                        EMPTY:   if (w_inXfer) w_nextState = ONE;
                        ONE: begin
                            if (w_inXfer && !w_outXfer)      w_nextState = TWO;
                            else if (!w_inXfer && w_outXfer) w_nextState = EMPTY;
                        end
                        TWO:     if (w_outXfer) w_nextState = ONE;
                        default: w_nextState = EMPTY;
                    endcase
                end
            end

            // in_ready is precomputed from next state so the upstream sees a flop, not logic.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_state   <= EMPTY;
                    r_inReady <= 1'b1;
                end else begin
                    r_state   <= w_nextState;
                    r_inReady <= (w_nextState != TWO);
                end
            end

            always_ff @(posedge CLK) begin
                if (!RST && !flush) begin
                    case (r_state)
                        EMPTY: if (w_inXfer) r_main <= in_data;
                        ONE: begin
                            if (w_inXfer && w_outXfer) r_main <= in_data;
                            else if (w_inXfer)         r_skid <= in_data;
                        end
                        TWO:   if (w_outXfer) r_main <= r_skid;
                        default: ;
                    endcase
                end
            end

            assign in_ready  = r_inReady;
            assign out_valid = (r_state != EMPTY);
            assign out_data  = out_valid ? r_main : NOP_VALUE;
            assign occupancy = r_state;
        end else begin : gen_single
            logic             r_valid;
            logic [WIDTH-1:0] r_main;
            logic             w_inReady;
            logic             w_inXfer;

            // Accepting while draining lets the single entry sustain one transfer per cycle.
            assign w_inReady = !r_valid || out_ready;
            assign w_inXfer  = in_valid && w_inReady;

            always_ff @(posedge CLK) begin
                if (RST || flush) begin
                    r_valid <= 1'b0;
                end else if (w_inXfer) begin
                    r_valid <= 1'b1;
                end else if (out_ready) begin
                    r_valid <= 1'b0;
                end
            end

            always_ff @(posedge CLK) begin
                if (!RST && !flush && w_inXfer) begin
                    r_main <= in_data;
                end
            end

            assign in_ready  = w_inReady;
            assign out_valid = r_valid;
            assign out_data  = r_valid ? r_main : NOP_VALUE;
            assign occupancy = {1'b0, r_valid};
        end
    endgenerate

    // Flush deliberately leaves this alone so stall statistics survive hazard recovery.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stallCnt <= '0;
        end else if (out_valid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench: skid stage (16-bit counter), skid stage with 4-bit counter for saturation,
// and a single-entry stage, all sharing one set of input drivers.
module tb_pipeline_stage_reg;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         aInReady, aOutValid, bInReady, bOutValid, cInReady, cOutValid;
    logic [W-1:0] aOutData, bOutData, cOutData;
    logic [1:0]   aOcc, bOcc, cOcc;
    logic [15:0]  aStall, cStall;
    logic [3:0]   bStall;

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 CLK = ~CLK;

    pipeline_stage_reg #(.WIDTH(W), .SKID(1), .NOP_VALUE('0), .CNT_W(16)) dutA (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(aInReady),
        .in_data(in_data), .out_valid(aOutValid), .out_ready(out_ready), .out_data(aOutData),
        .occupancy(aOcc), .stall_cnt(aStall));

    pipeline_stage_reg #(.WIDTH(W), .SKID(1), .NOP_VALUE('0), .CNT_W(4)) dutB (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(bInReady),
        .in_data(in_data), .out_valid(bOutValid), .out_ready(out_ready), .out_data(bOutData),
        .occupancy(bOcc), .stall_cnt(bStall));

    pipeline_stage_reg #(.WIDTH(W), .SKID(0), .NOP_VALUE('0), .CNT_W(16)) dutC (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(cInReady),
        .in_data(in_data), .out_valid(cOutValid), .out_ready(out_ready), .out_data(cOutData),
        .occupancy(cOcc), .stall_cnt(cStall));

    typedef struct {
        logic         flush;
        logic         inValid;
        logic [W-1:0] inData;
        logic         outReady;
        logic         expValid;
        logic [W-1:0] expData;
        logic [1:0]   expOcc;
        logic         expReady;
        logic [15:0]  expStall;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [W-1:0] id,
                                input logic ordy, input logic ev, input logic [W-1:0] ed,
                                input logic [1:0] eo, input logic er, input logic [15:0] es);
        vec_t v;
        v.flush = fl; v.inValid = iv; v.inData = id; v.outReady = ordy;
        v.expValid = ev; v.expData = ed; v.expOcc = eo; v.expReady = er; v.expStall = es;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passCnt++;
    endtask

    task automatic applyStimulus(input logic fl, input logic iv, input logic [W-1:0] id,
                                 input logic ordy);
        flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h55; out_ready = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        // Hand-computed expectations for the skid stage (dutA), applied one edge per row.
        vecs[0]  = mk(0, 1, 16'h1,    1, 1, 16'h1, 2'd1, 1, 16'd0);
        vecs[1]  = mk(0, 1, 16'h2,    1, 1, 16'h2, 2'd1, 1, 16'd0);
        vecs[2]  = mk(0, 1, 16'h3,    1, 1, 16'h3, 2'd1, 1, 16'd0);
        vecs[3]  = mk(0, 0, 16'h0,    1, 0, 16'h0, 2'd0, 1, 16'd0);
        vecs[4]  = mk(0, 1, 16'hA,    0, 1, 16'hA, 2'd1, 1, 16'd0);
        vecs[5]  = mk(0, 1, 16'hB,    0, 1, 16'hA, 2'd2, 0, 16'd1);
        vecs[6]  = mk(0, 1, 16'hC,    0, 1, 16'hA, 2'd2, 0, 16'd2);
        vecs[7]  = mk(0, 1, 16'hC,    1, 1, 16'hB, 2'd1, 1, 16'd2);
        vecs[8]  = mk(0, 1, 16'hC,    1, 1, 16'hC, 2'd1, 1, 16'd2);
        vecs[9]  = mk(0, 0, 16'h0,    1, 0, 16'h0, 2'd0, 1, 16'd2);
        vecs[10] = mk(0, 1, 16'hE,    0, 1, 16'hE, 2'd1, 1, 16'd2);
        vecs[11] = mk(0, 1, 16'hF,    0, 1, 16'hE, 2'd2, 0, 16'd3);
        vecs[12] = mk(1, 1, 16'hD,    1, 0, 16'h0, 2'd0, 1, 16'd3);
        vecs[13] = mk(0, 1, 16'h7,    1, 1, 16'h7, 2'd1, 1, 16'd3);
        vecs[14] = mk(1, 1, 16'hD,    1, 0, 16'h0, 2'd0, 1, 16'd3);
        vecs[15] = mk(0, 0, 16'h0,    1, 0, 16'h0, 2'd0, 1, 16'd3);
        vecs[16] = mk(0, 0, 16'hxxxx, 1, 0, 16'h0, 2'd0, 1, 16'd3);

        doReset();
        checkOutput("rst_valid", {31'd0, aOutValid}, 32'd0);
        checkOutput("rst_data",  {16'd0, aOutData},  32'd0);
        checkOutput("rst_occ",   {30'd0, aOcc},      32'd0);
        checkOutput("rst_stall", {16'd0, aStall},    32'd0);
        checkOutput("rst_ready", {31'd0, aInReady},  32'd1);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].flush, vecs[i].inValid, vecs[i].inData, vecs[i].outReady);
            checkOutput($sformatf("v%0d_valid", i), {31'd0, aOutValid}, {31'd0, vecs[i].expValid});
            checkOutput($sformatf("v%0d_data", i),  {16'd0, aOutData},  {16'd0, vecs[i].expData});
            checkOutput($sformatf("v%0d_occ", i),   {30'd0, aOcc},      {30'd0, vecs[i].expOcc});
            checkOutput($sformatf("v%0d_ready", i), {31'd0, aInReady},  {31'd0, vecs[i].expReady});
            checkOutput($sformatf("v%0d_stall", i), {16'd0, aStall},    {16'd0, vecs[i].expStall});
        end

        // Saturation: one held entry, downstream blocked for 20 edges.
        doReset();
        applyStimulus(0, 1, 16'h9, 0);
        checkOutput("sat_loaded", {31'd0, bOutValid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 16'h0, 0);
            if (i == 13) checkOutput("sat_b14", {28'd0, bStall}, 32'd14);
            if (i == 14) checkOutput("sat_b15", {28'd0, bStall}, 32'd15);
        end
        checkOutput("sat_b_hold", {28'd0, bStall}, 32'd15);
        checkOutput("sat_a_20",   {16'd0, aStall}, 32'd20);
        checkOutput("sat_b_data", {16'd0, bOutData}, 32'h9);

        // Single-entry stage: combinational in_ready and replace-while-draining.
        doReset();
        applyStimulus(0, 1, 16'h4, 0);
        checkOutput("s0_data4",   {16'd0, cOutData}, 32'h4);
        checkOutput("s0_occ1",    {30'd0, cOcc},     32'd1);
        checkOutput("s0_blocked", {31'd0, cInReady}, 32'd0);
        applyStimulus(0, 1, 16'h6, 0);
        checkOutput("s0_hold4",   {16'd0, cOutData}, 32'h4);
        checkOutput("s0_stall1",  {16'd0, cStall},   32'd1);
        in_data = 16'h5; out_ready = 1'b1;
        #1;
        checkOutput("s0_ready",   {31'd0, cInReady}, 32'd1);
        applyStimulus(0, 1, 16'h5, 1);
        checkOutput("s0_data5",   {16'd0, cOutData}, 32'h5);
        checkOutput("s0_occ5",    {30'd0, cOcc},     32'd1);
        checkOutput("s0_valid5",  {31'd0, cOutValid}, 32'd1);
        applyStimulus(0, 0, 16'h0, 1);
        checkOutput("s0_drained", {31'd0, cOutValid}, 32'd0);
        checkOutput("s0_nop",     {16'd0, cOutData}, 32'd0);
        checkOutput("s0_occ0",    {30'd0, cOcc},     32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
